// File: rtl/video_pkg.sv
// Shared video constants and types for the luma / FIR front end.
package video_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned COL_W_DEF = 11;
  localparam int unsigned ROW_W_DEF = 10;
  localparam int unsigned MAX_COLS  = 1600;
  localparam int unsigned MAX_ROWS  = 900;

  // BT.601 luma weights scaled by 256; they sum to exactly 256 so white maps to 255.
  localparam int unsigned BT601_KR = 77;
  localparam int unsigned BT601_KG = 150;
  localparam int unsigned BT601_KB = 29;

  // One pixel's worth of sync flags travelling down the delay line.
  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/video_pos_cnt.sv
// Pixel position tracker driven by pipeline-aligned dv/hs/vs.
// Produces column, row, last line length and a frame-start pulse that line up
// cycle for cycle with whatever data stream the syncs qualify.
module video_pos_cnt
  import video_pkg::*;
#(
  parameter int unsigned COL_W = COL_W_DEF,
  parameter int unsigned ROW_W = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dv,
  input  logic             hs,
  input  logic             vs,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] line_len,
  output logic             frame_start
);

  localparam logic [COL_W-1:0] COL_MAX = '1;
  localparam logic [ROW_W-1:0] ROW_MAX = '1;

  logic             hs_q, vs_q;
  logic             line_act;
  logic             vs_seen;
  logic             hs_rise, hs_fall, vs_fall;
  logic [COL_W-1:0] col_cnt;

  assign hs_rise = hs & ~hs_q;
  assign hs_fall = ~hs & hs_q;
  assign vs_fall = ~vs & vs_q;

  // Count including the current pixel, saturating; a pixel coincident with
  // the hs edge still belongs to the line that is ending.
  assign col_cnt = (dv && col != COL_MAX) ? col + 1'b1 : col;

  // A vs falling edge in the same cycle as the first pixel still arms the pulse.
  assign frame_start = dv & (vs_seen | vs_fall);

  // Registered sync copies for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;
    end
  end

  // Column counter and line-length capture on the hs rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col      <= '0;
      line_len <= '0;
    end else begin
      if (vs || hs_rise) col <= '0;
      else               col <= col_cnt;
      if (hs_rise) line_len <= col_cnt;
    end
  end

  // Row counter: only lines that carried at least one pixel advance it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row      <= '0;
      line_act <= 1'b0;
    end else if (vs) begin
      row      <= '0;
      line_act <= 1'b0;
    end else if (hs_fall) begin
      if (line_act && row != ROW_MAX) row <= row + 1'b1;
      line_act <= dv;
    end else if (dv) begin
      line_act <= 1'b1;
    end
  end

  // Arm on vs falling edge, disarm when the frame's first pixel goes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              vs_seen <= 1'b0;
    else if (frame_start) vs_seen <= 1'b0;
    else if (vs_fall)     vs_seen <= 1'b1;
  end

endmodule

// File: rtl/rgb_to_luma.sv
// Three-stage RGB -> Y (BT.601 integer) converter with matching sync delay
// and pixel position outputs for the downstream filter.
module rgb_to_luma
  import video_pkg::*;
#(
  parameter int unsigned KR    = BT601_KR,
  parameter int unsigned KG    = BT601_KG,
  parameter int unsigned KB    = BT601_KB,
  parameter int unsigned COL_W = COL_W_DEF,
  parameter int unsigned ROW_W = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] r_i,
  input  logic [PIX_W-1:0] g_i,
  input  logic [PIX_W-1:0] b_i,
  input  logic             dv_i,
  input  logic             hs_i,
  input  logic             vs_i,
  output logic [PIX_W-1:0] y_o,
  output logic             dv_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] line_len_o,
  output logic             frame_start_o
);

  localparam int unsigned STAGES = 3;

  localparam logic [7:0] KR_C = KR[7:0];
  localparam logic [7:0] KG_C = KG[7:0];
  localparam logic [7:0] KB_C = KB[7:0];

  logic [15:0]            pr, pg, pb;
  logic [16:0]            sum;
  logic [PIX_W-1:0]       y_q;
  sync_t [STAGES:1]       sync_pipe;

  // S1: per-channel weighted products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr <= '0;
      pg <= '0;
      pb <= '0;
    end else begin
      pr <= {8'd0, KR_C} * {8'd0, r_i};
      pg <= {8'd0, KG_C} * {8'd0, g_i};
      pb <= {8'd0, KB_C} * {8'd0, b_i};
    end
  end

  // S2: sum plus half an LSB of the output so the truncation rounds half-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= '0;
    else     sum <= {1'b0, pr} + {1'b0, pg} + {1'b0, pb} + 17'd128;
  end

  // S3: take the integer part. Bit 16 cannot be set with weights summing to
  // 256; clamping keeps other coefficient sets from wrapping to dark pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= '0;
    else     y_q <= sum[16] ? '1 : sum[15:8];
  end

  // Sync delay line, one slot per arithmetic stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[STAGES-1:1], sync_t'{dv: dv_i, hs: hs_i, vs: vs_i}};
  end

  assign y_o  = y_q;
  assign dv_o = sync_pipe[STAGES].dv;
  assign hs_o = sync_pipe[STAGES].hs;
  assign vs_o = sync_pipe[STAGES].vs;

  video_pos_cnt #(
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .dv          (dv_o),
    .hs          (hs_o),
    .vs          (vs_o),
    .col         (col_o),
    .row         (row_o),
    .line_len    (line_len_o),
    .frame_start (frame_start_o)
  );

endmodule

// File: tb/tb_rgb_to_luma.sv
// Bench for rgb_to_luma: reference model of luma and pixel position over the
// input stream, compared 3 cycles later on every falling clock edge, plus
// directed literal checks of colours, frame timing, saturation and reset.
module tb_rgb_to_luma;
  import video_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] r_i = '0, g_i = '0, b_i = '0;
  logic dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;

  logic [7:0]  y_o;
  logic        dv_o, hs_o, vs_o, frame_start_o;
  logic [10:0] col_o, line_len_o;
  logic [9:0]  row_o;

  logic [7:0]  y_s;
  logic        dv_s, hs_s, vs_s, fs_s;
  logic [2:0]  col_s, len_s;
  logic [9:0]  row_s;

  always #5 clk = ~clk;

  rgb_to_luma dut (
    .clk(clk), .rst(rst), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .y_o(y_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .col_o(col_o), .row_o(row_o), .line_len_o(line_len_o),
    .frame_start_o(frame_start_o)
  );

  rgb_to_luma #(.COL_W(3)) dut_s (
    .clk(clk), .rst(rst), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .y_o(y_s), .dv_o(dv_s), .hs_o(hs_s), .vs_o(vs_s),
    .col_o(col_s), .row_o(row_s), .line_len_o(len_s),
    .frame_start_o(fs_s)
  );

  int n_chk = 0;
  int n_err = 0;
  int col_sum = 0, row_sum = 0, fs_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int r, g, b, y;
    logic dv, hs, vs, fs;
    int col, row, len, col3, len3;
  } exp_t;

  typedef struct {
    logic phs, pvs, act, seen;
    int col, row, len, col3, len3;
  } ms_t;

  function automatic int model_y(int r, int g, int b);
    real s;
    s = real'(BT601_KR) * r + real'(BT601_KG) * g + real'(BT601_KB) * b;
    return int'($floor(s / 256.0 + 0.5));
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.r = 0; e.g = 0; e.b = 0; e.y = 0;
    e.dv = 0; e.hs = 0; e.vs = 0; e.fs = 0;
    e.col = 0; e.row = 0; e.len = 0; e.col3 = 0; e.len3 = 0;
    return e;
  endfunction

  function automatic ms_t ms_zero();
    ms_t m;
    m.phs = 0; m.pvs = 0; m.act = 0; m.seen = 0;
    m.col = 0; m.row = 0; m.len = 0; m.col3 = 0; m.len3 = 0;
    return m;
  endfunction

  // What the outputs must show when this input sample reaches the output.
  function automatic exp_t mk_exp(ms_t m, int r, int g, int b, logic dv, logic hs, logic vs);
    exp_t e;
    e.r = r; e.g = g; e.b = b; e.y = model_y(r, g, b);
    e.dv = dv; e.hs = hs; e.vs = vs;
    e.fs = dv && (m.seen || (m.pvs && !vs));
    e.col = m.col; e.row = m.row; e.len = m.len;
    e.col3 = m.col3; e.len3 = m.len3;
    return e;
  endfunction

  // Position bookkeeping after one sample, from the line/frame rules.
  function automatic ms_t step(ms_t m, logic dv, logic hs, logic vs);
    ms_t n;
    logic rise, fall, vfall;
    int c1, c3;
    n = m;
    rise  = hs && !m.phs;
    fall  = !hs && m.phs;
    vfall = !vs && m.pvs;
    c1 = (dv && m.col  < 2047) ? m.col  + 1 : m.col;
    c3 = (dv && m.col3 < 7)    ? m.col3 + 1 : m.col3;
    if (rise) begin n.len = c1; n.len3 = c3; end
    n.col  = (vs || rise) ? 0 : c1;
    n.col3 = (vs || rise) ? 0 : c3;
    if (vs) begin
      n.row = 0; n.act = 0;
    end else if (fall) begin
      if (m.act && m.row < 1023) n.row = m.row + 1;
      n.act = dv;
    end else begin
      n.act = m.act | dv;
    end
    if (dv && (m.seen || vfall)) n.seen = 0;
    else if (vfall)              n.seen = 1;
    n.phs = hs; n.pvs = vs;
    return n;
  endfunction

  exp_t h [3];
  ms_t  ms;

  initial begin
    for (int i = 0; i < 3; i++) h[i] = zero_exp();
    ms = ms_zero();
  end

  // Record each sampled input; reset wipes everything in flight.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h[0] <= zero_exp(); h[1] <= zero_exp(); h[2] <= zero_exp();
      ms   <= ms_zero();
    end else begin
      h[0] <= mk_exp(ms, int'(r_i), int'(g_i), int'(b_i), dv_i, hs_i, vs_i);
      h[1] <= h[0];
      h[2] <= h[1];
      ms   <= step(ms, dv_i, hs_i, vs_i);
    end
  end

  task automatic compare();
    real yr, d;
    chk("y_o",        int'(y_o),           h[2].y);
    chk("dv_o",       int'(dv_o),          int'(h[2].dv));
    chk("hs_o",       int'(hs_o),          int'(h[2].hs));
    chk("vs_o",       int'(vs_o),          int'(h[2].vs));
    chk("col_o",      int'(col_o),         h[2].col);
    chk("row_o",      int'(row_o),         h[2].row);
    chk("line_len_o", int'(line_len_o),    h[2].len);
    chk("frame_start",int'(frame_start_o), int'(h[2].fs));
    chk("col_o sat",  int'(col_s),         h[2].col3);
    chk("len sat",    int'(len_s),         h[2].len3);
    if (h[2].dv) begin
      yr = 0.299 * h[2].r + 0.587 * h[2].g + 0.114 * h[2].b;
      d  = real'(y_o) - yr;
      n_chk++;
      if (d > 1.0 || d < -1.0) begin
        n_err++;
        $display("FAIL y_float: got %0d, reference %f", y_o, yr);
      end
      col_sum += int'(col_o);
      row_sum += int'(row_o);
    end
    if (frame_start_o) fs_cnt++;
  endtask

  always @(negedge clk) compare();

  // ---------------- stimulus ----------------
  task automatic cyc(input int r, input int g, input int b,
                     input logic dv, input logic hs, input logic vs);
    @(posedge clk); #1;
    r_i = 8'(r); g_i = 8'(g); b_i = 8'(b);
    dv_i = dv; hs_i = hs; vs_i = vs;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic px_lit(input int r, input int g, input int b,
                        input logic hs, input logic vs, input int ey);
    cyc(r, g, b, 1, hs, vs);
    idle(2);
    chk("lit dv_o early", int'(dv_o), 0);
    idle(1);
    chk("lit y_o",  int'(y_o),  ey);
    chk("lit dv_o", int'(dv_o), 1);
    chk("lit hs_o", int'(hs_o), int'(hs));
    chk("lit vs_o", int'(vs_o), int'(vs));
  endtask

  initial begin
    int c0, r0, f0;

    chk("model y red",   model_y(255, 0, 0),     77);
    chk("model y green", model_y(0, 255, 0),     149);
    chk("model y white", model_y(255, 255, 255), 255);

    repeat (2) @(posedge clk);
    #1;
    chk("rst y_o",        int'(y_o),           0);
    chk("rst dv_o",       int'(dv_o),          0);
    chk("rst line_len_o", int'(line_len_o),    0);
    chk("rst frame_start",int'(frame_start_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

    // Gray, extremes and primaries with sync flags riding along.
    px_lit(0,   0,   0,   0, 0, 0);
    px_lit(255, 255, 255, 1, 0, 255);
    px_lit(128, 128, 128, 0, 0, 128);
    px_lit(255, 0,   0,   0, 1, 77);
    px_lit(0,   255, 0,   0, 0, 149);
    px_lit(0,   0,   255, 1, 1, 29);
    idle(3);

    // Frame: 4 lines x 8 px with vs and hs blanking.
    c0 = col_sum; r0 = row_sum; f0 = fs_cnt;
    cyc(0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 1);
    idle(2);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) cyc(p * 30, l * 60, 255 - p * 20, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0);
      idle(6);
      chk("frame line_len", int'(line_len_o), 8);
      chk("frame row",      int'(row_o),      l + 1);
    end
    chk("frame col sum",  col_sum - c0, 4 * 28);
    chk("frame row sum",  row_sum - r0, 8 * (0 + 1 + 2 + 3));
    chk("frame fs count", fs_cnt - f0,  1);

    // hs pulse with no pixels: row holds, length captures zero.
    cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0);
    idle(6);
    chk("empty row",      int'(row_o),      4);
    chk("empty line_len", int'(line_len_o), 0);

    // 10 px line: the 3-bit column instance saturates at 7.
    for (int p = 0; p < 10; p++) cyc(10 * p, 20, 30, 1, 0, 0);
    idle(4);
    chk("sat col_s", int'(col_s), 7);
    chk("sat col_o", int'(col_o), 10);
    cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0);
    idle(6);
    chk("sat len_s",      int'(len_s),      7);
    chk("sat line_len_o", int'(line_len_o), 10);

    // Mid-line reset, then no frame_start until a fresh vs.
    cyc(0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 1);
    idle(2);
    repeat (7) cyc(200, 100, 50, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async y_o",        int'(y_o),           0);
    chk("async dv_o",       int'(dv_o),          0);
    chk("async col_o",      int'(col_o),         0);
    chk("async row_o",      int'(row_o),         0);
    chk("async line_len_o", int'(line_len_o),    0);
    chk("async len_s",      int'(len_s),         0);
    chk("async frame_start",int'(frame_start_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    f0 = fs_cnt;
    repeat (12) cyc(200, 100, 50, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0);
    idle(6);
    chk("post-rst no fs", fs_cnt - f0, 0);
    f0 = fs_cnt;
    cyc(0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 1);
    idle(2);
    repeat (8) cyc(90, 180, 45, 1, 0, 0);
    idle(6);
    chk("post-vs fs", fs_cnt - f0, 1);

    // Random stream with periodic hs/vs.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(255), $urandom_range(255), $urandom_range(255),
          ($urandom_range(3) != 0), ((i % 24) >= 21), ((i % 200) < 3));
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
